// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Streaming accumulator that sits after the combinational multiplier. A job is
// requested with start/len. The block then takes len unsigned products over a
// valid/ready handshake and adds them into a saturating accumulator. The total
// is then offered on a valid/ready result port. Together with the multiplier
// this forms the multiply-accumulate (dot-product) datapath.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   start           single-cycle job request, sampled only in IDLE
//   len             products in the job, sampled with start (0 = empty job)
//   busy            high whenever the block is not IDLE
//   producto        unsigned 2*DATA_WIDTH product from the multiplier
//   producto_valid  producto is valid
//   producto_ready  block accepts producto this cycle (ACCUM only)
//   acumulado       accumulator value; valid only while acumulado_valid
//   acumulado_valid result is valid (DONE)
//   acumulado_ready downstream accepts the result
//   overflow        sticky saturation flag for the current or last job
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter  int MAX_LEN    = 256,
    localparam int LW         = $clog2(MAX_LEN+1),
    localparam int PW         = 2*DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LW-1:0]        len,
    output logic                 busy,
    input  logic [PW-1:0]        producto,
    input  logic                 producto_valid,
    output logic                 producto_ready,
    output logic [ACC_WIDTH-1:0] acumulado,
    output logic                 acumulado_valid,
    input  logic                 acumulado_ready,
    output logic                 overflow
);

    // The accumulator must be able to hold at least one full product.
    if (ACC_WIDTH < PW) begin : g_width_check
        $error("product_accumulator: ACC_WIDTH must be >= 2*DATA_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q,   acc_d;
    logic [LW-1:0]          count_q, count_d;
    logic                   ovf_q,   ovf_d;

    // The extra top bit of the sum is the carry-out that triggers saturation.
    logic [ACC_WIDTH:0]     sum;

    assign sum = {1'b0, acc_q} + (ACC_WIDTH+1)'(producto);

    // Handshake signals are decoded from the state, so they are never registered.
    assign busy            = (state_q != S_IDLE);
    assign producto_ready  = (state_q == S_ACCUM);
    assign acumulado_valid = (state_q == S_DONE);
    assign acumulado       = acc_q;
    assign overflow        = ovf_q;

    // NOTE: every always_comb output gets a hold default first. Then no path
    // leaves a variable unassigned, and no latch is inferred.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = len;
                    state_d = (len == '0) ? S_DONE : S_ACCUM;
                end
            end

            S_ACCUM: begin
                if (producto_valid) begin
                    // Once saturated, the value stays pinned at all-ones until the job ends.
                    if (sum[ACC_WIDTH] || ovf_q) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_WIDTH-1:0];
                    end
                    count_d = count_q - LW'(1);
                    if (count_q == LW'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // The result and flag hold until downstream takes them.
                if (acumulado_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. All registers then
    // update together at the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
